// File: rtl/serial_to_parallel_if.sv
// Bus bundle for serial_to_parallel: serial bit input and word-wide output
// handshakes. The parity error flag exists only when SER2PAR_PARITY_EN is
// defined.
interface serial_to_parallel_if #(
  parameter int NBITS = 8
);
  logic             in_val;
  logic             in_rdy;
  logic             in_bit;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_msg;
`ifdef SER2PAR_PARITY_EN
  logic             out_err;

  modport master (
    output in_val, in_bit, out_rdy,
    input  in_rdy, out_val, out_msg, out_err
  );

  modport slave (
    input  in_val, in_bit, out_rdy,
    output in_rdy, out_val, out_msg, out_err
  );
`else
  modport master (
    output in_val, in_bit, out_rdy,
    input  in_rdy, out_val, out_msg
  );

  modport slave (
    input  in_val, in_bit, out_rdy,
    output in_rdy, out_val, out_msg
  );
`endif
endinterface

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: gathers 1-bit transfers LSB first into an NBITS-wide
// word and offers it on a val/rdy output. Optional even-parity trailer bit
// and out_err flag are enabled by defining SER2PAR_PARITY_EN.
module serial_to_parallel #(
  parameter int NBITS = 8
) (
  input logic            clk,
  input logic            reset,
  serial_to_parallel_if.slave io
);

`ifdef SER2PAR_PARITY_EN
  localparam int CW = $clog2(NBITS + 2);
  localparam logic [CW-1:0] PAR_IDX = CW'(NBITS);
`else
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(NBITS - 1);
`endif

  typedef enum logic {
    SHIFT = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NBITS-1:0] msg_q, msg_d;
  logic             val_q, val_d;
  logic             in_fire;
`ifdef SER2PAR_PARITY_EN
  logic             par_q, par_d;
  logic             err_q, err_d;
`endif

  assign io.in_rdy  = (state_q == SHIFT) && !reset;
  assign in_fire    = io.in_val && io.in_rdy;
  assign io.out_val = val_q;
  assign io.out_msg = msg_q;
`ifdef SER2PAR_PARITY_EN
  assign io.out_err = err_q;
`endif

  // State register; reset clears the pending word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHIFT;
      count_q <= '0;
      msg_q   <= '0;
      val_q   <= 1'b0;
`ifdef SER2PAR_PARITY_EN
      par_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      msg_q   <= msg_d;
      val_q   <= val_d;
`ifdef SER2PAR_PARITY_EN
      par_q   <= par_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state: shift bits in while SHIFT, hold word in FULL until taken.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    msg_d   = msg_q;
    val_d   = val_q;
`ifdef SER2PAR_PARITY_EN
    par_d   = par_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      SHIFT: begin
        if (in_fire) begin
          count_d = count_q + CW'(1);
          // Decoded write keeps the index the same width as the counter;
          // the parity slot (count == NBITS) matches no data bit.
          for (int unsigned i = 0; i < NBITS; i++) begin
            if (count_q == CW'(i)) begin
              msg_d[i] = io.in_bit;
            end
          end
`ifdef SER2PAR_PARITY_EN
          par_d = par_q ^ io.in_bit;
          if (count_q == PAR_IDX) begin
            state_d = FULL;
            val_d   = 1'b1;
            err_d   = par_q ^ io.in_bit;
          end
`else
          if (count_q == LAST_DATA) begin
            state_d = FULL;
            val_d   = 1'b1;
          end
`endif
        end
      end
      FULL: begin
        if (val_q && io.out_rdy) begin
          state_d = SHIFT;
          count_d = '0;
          val_d   = 1'b0;
`ifdef SER2PAR_PARITY_EN
          par_d   = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = SHIFT;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (NBITS = 8). Parity cases are built
// when SER2PAR_PARITY_EN is defined.
module tb_serial_to_parallel;

`ifdef SER2PAR_PARITY_EN
  localparam int NW = 9;
`else
  localparam int NW = 8;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   val_cycles;
  int   base;

  serial_to_parallel_if #(.NBITS(8)) bus ();

  serial_to_parallel #(.NBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count cycles in which a completed word is presented.
  always @(negedge clk) begin
    if (bus.out_val === 1'b1) val_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Send one word LSB first; p is the trailing parity bit in parity builds.
  task automatic send_word(input logic [7:0] w, input logic p);
    logic [8:0] seq;
    seq = {p, w};
    for (int i = 0; i < NW; i++) begin
      bus.in_val = 1'b1;
      bus.in_bit = seq[i];
      if (i == 0) check("in_rdy_first_bit", {31'd0, bus.in_rdy}, 32'd1);
      if (i == NW - 1) check("out_val_before_last", {31'd0, bus.out_val}, 32'd0);
      tick();
    end
    bus.in_val = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    val_cycles  = 0;
    reset       = 1'b1;
    bus.in_val  = 1'b0;
    bus.in_bit  = 1'b0;
    bus.out_rdy = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_rdy", {31'd0, bus.in_rdy}, 32'd0);
    check("rst_out_val", {31'd0, bus.out_val}, 32'd0);
    check("rst_out_msg", {24'd0, bus.out_msg}, 32'h00);
    reset = 1'b0;
    #1;
    check("rel_in_rdy", {31'd0, bus.in_rdy}, 32'd1);

    // Basic word 0xA5
    bus.out_rdy = 1'b1;
    send_word(8'hA5, 1'b0);
    check("basic_val", {31'd0, bus.out_val}, 32'd1);
    check("basic_msg", {24'd0, bus.out_msg}, 32'hA5);
    check("basic_full_rdy", {31'd0, bus.in_rdy}, 32'd0);
    tick();
    check("basic_val_drop", {31'd0, bus.out_val}, 32'd0);
    check("basic_rdy_back", {31'd0, bus.in_rdy}, 32'd1);

    // Back-pressure with 0x3C, in_val held high with 1s
    bus.out_rdy = 1'b0;
    send_word(8'h3C, 1'b0);
    bus.in_val = 1'b1;
    bus.in_bit = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("bp_val", {31'd0, bus.out_val}, 32'd1);
      check("bp_rdy", {31'd0, bus.in_rdy}, 32'd0);
      check("bp_msg", {24'd0, bus.out_msg}, 32'h3C);
      tick();
    end
    bus.in_val  = 1'b0;
    bus.out_rdy = 1'b1;
    check("bp_msg_held", {24'd0, bus.out_msg}, 32'h3C);
    tick();
    check("bp_val_drop", {31'd0, bus.out_val}, 32'd0);
    send_word(8'h42, 1'b0);
    check("bp_next_msg", {24'd0, bus.out_msg}, 32'h42);
    check("bp_next_val", {31'd0, bus.out_val}, 32'd1);
    tick();

    // Input gaps: 0xF0 with 2-cycle gaps after bit 3 and bit 6
    for (int i = 0; i < 8; i++) begin
      bus.in_val = 1'b1;
      bus.in_bit = (i >= 4) ? 1'b1 : 1'b0;
      tick();
      bus.in_val = 1'b0;
      if (i == 3 || i == 6) begin
        tick();
        tick();
        check("gap_val_low", {31'd0, bus.out_val}, 32'd0);
      end
    end
`ifdef SER2PAR_PARITY_EN
    bus.in_val = 1'b1;
    bus.in_bit = 1'b0;
    tick();
    bus.in_val = 1'b0;
`endif
    check("gap_val", {31'd0, bus.out_val}, 32'd1);
    check("gap_msg", {24'd0, bus.out_msg}, 32'hF0);
    tick();
    check("gap_val_drop", {31'd0, bus.out_val}, 32'd0);

    // Asynchronous reset while a word is pending in FULL
    bus.out_rdy = 1'b0;
    send_word(8'hA5, 1'b0);
    check("full_val", {31'd0, bus.out_val}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_full_val", {31'd0, bus.out_val}, 32'd0);
    check("async_full_msg", {24'd0, bus.out_msg}, 32'h00);
    check("async_full_rdy", {31'd0, bus.in_rdy}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_rel_rdy", {31'd0, bus.in_rdy}, 32'd1);
    tick();

    // Reset mid-word: five 1s, reset pulse, then 0x81
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_val = 1'b1;
      bus.in_bit = 1'b1;
      tick();
    end
    bus.in_val = 1'b0;
    check("partial_msg", {24'd0, bus.out_msg}, 32'h1F);
    check("partial_val", {31'd0, bus.out_val}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_msg", {24'd0, bus.out_msg}, 32'h00);
    #2 reset = 1'b0;
    tick();
    base = val_cycles;
    send_word(8'h81, 1'b0);
    check("mid_msg", {24'd0, bus.out_msg}, 32'h81);
    check("mid_val", {31'd0, bus.out_val}, 32'd1);
    tick();
    check("mid_val_drop", {31'd0, bus.out_val}, 32'd0);
    tick();
    tick();
    check("mid_val_count", val_cycles - base, 32'd1);

`ifdef SER2PAR_PARITY_EN
    // Parity: good and bad trailer on 0xA5
    send_word(8'hA5, 1'b0);
    check("par_ok_err", {31'd0, bus.out_err}, 32'd0);
    check("par_ok_msg", {24'd0, bus.out_msg}, 32'hA5);
    tick();
    send_word(8'hA5, 1'b1);
    check("par_bad_err", {31'd0, bus.out_err}, 32'd1);
    check("par_bad_msg", {24'd0, bus.out_msg}, 32'hA5);
    tick();
    check("par_err_clear", {31'd0, bus.out_err}, 32'd0);
`endif

    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
